// File: rtl/speed_key_sequencer.sv
// speed_key_sequencer: three raw active-low buttons -> clean 1-cycle step
// commands (faster / slower / restore) for the divisor generator.
//
// Per key: 2-flop synchronizer, then a counting debouncer. A small FSM turns
// the debounced levels into registered command pulses; restore outranks the
// step keys, and pressing both step keys together is ignored until release.
//
// Build option:
//   SPEED_KEY_AUTOREPEAT_EN  defined   -> held step key auto-repeats
//                            undefined -> one pulse per press, no repeat logic

// ---------------------------------------------------------------------------
// One key lane: synchronize the raw level, then accept a change only after
// DEBOUNCE_CYCLES consecutive samples that disagree with the current level.
// ---------------------------------------------------------------------------
module speed_key_debounce #(
  parameter int DEBOUNCE_CYCLES = 50_000,
  parameter int CNT_W           = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic deb
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             p;

  // synchronizer shift and debounce counter; any agreeing sample restarts it
  always_comb begin
    sync1_d = key_n;
    sync2_d = sync1_q;
    p       = ~sync2_q;
    deb_d   = deb_q;
    cnt_d   = cnt_q;
    if (p == deb_q) begin
      cnt_d = '0;
    end else if (cnt_q >= CNT_LAST) begin
      deb_d = p;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // sync flops reset to "released" so a key held through reset needs a full debounce
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign deb = deb_q;
endmodule

// ---------------------------------------------------------------------------
// Top: three debounce lanes feeding the command FSM.
// ---------------------------------------------------------------------------
module speed_key_sequencer #(
  parameter int DEBOUNCE_CYCLES = 50_000,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_RATE     = 2_500_000,
  parameter int CNT_W           = 32
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_faster_n,
  input  logic key_slower_n,
  input  logic key_restore_n,
  output logic cmd_faster,
  output logic cmd_slower,
  output logic cmd_restore,
  output logic key_active
);
  localparam int NUM_KEYS = 3;
  localparam int K_FAST   = 0;
  localparam int K_SLOW   = 1;
  localparam int K_REST   = 2;

  // reject parameter sets the counters cannot represent
  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1 ||
      $clog2(DEBOUNCE_CYCLES) > CNT_W || $clog2(REPEAT_DELAY) > CNT_W ||
      $clog2(REPEAT_RATE) > CNT_W) begin : g_bad_param
    $error("speed_key_sequencer: parameters must be >= 1 and fit in CNT_W");
  end

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT, WAIT_REL} state_t;

  logic [NUM_KEYS-1:0] keys_n;
  logic [NUM_KEYS-1:0] deb;

  state_t              state_q, state_d;
  logic [NUM_KEYS-1:0] cmd_q, cmd_d;

  assign keys_n = {key_restore_n, key_slower_n, key_faster_n};

  speed_key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_deb [NUM_KEYS-1:0] (
    .clk  (clk),
    .rst_n(reset_n),
    .key_n(keys_n),
    .deb  (deb)
  );

`ifdef SPEED_KEY_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST = CNT_W'(REPEAT_RATE - 1);

  // sel: which step key owns HOLD/REPEAT (0 = faster, 1 = slower)
  logic             sel_q, sel_d;
  logic [CNT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic             held, other, rpt_last;

  // held/other are relative to the key that started the repeat
  always_comb begin
    held     = sel_q ? deb[K_SLOW] : deb[K_FAST];
    other    = deb[K_REST] | (sel_q ? deb[K_FAST] : deb[K_SLOW]);
    rpt_last = (state_q == HOLD) ? (rpt_cnt_q == DLY_LAST)
                                 : (rpt_cnt_q == RATE_LAST);
  end

  // repeat bookkeeping registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel_q     <= 1'b0;
      rpt_cnt_q <= '0;
    end else begin
      sel_q     <= sel_d;
      rpt_cnt_q <= rpt_cnt_d;
    end
  end
`endif

  // state register and registered command pulses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cmd_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
    end
  end

  // next state; at most one cmd_d bit is ever set
  always_comb begin
    state_d = state_q;
    cmd_d   = '0;
`ifdef SPEED_KEY_AUTOREPEAT_EN
    sel_d     = sel_q;
    rpt_cnt_d = rpt_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (deb[K_REST]) begin
          cmd_d[K_REST] = 1'b1;
          state_d       = WAIT_REL;
        end else if (deb[K_FAST] ^ deb[K_SLOW]) begin
          cmd_d[K_FAST] = deb[K_FAST];
          cmd_d[K_SLOW] = deb[K_SLOW];
`ifdef SPEED_KEY_AUTOREPEAT_EN
          sel_d     = deb[K_SLOW];
          rpt_cnt_d = '0;
          state_d   = HOLD;
`else
          state_d   = WAIT_REL;
`endif
        end else if (deb[K_FAST] & deb[K_SLOW]) begin
          state_d = WAIT_REL;
        end
      end
`ifdef SPEED_KEY_AUTOREPEAT_EN
      HOLD, REPEAT: begin
        // release or a competing key beats a terminal count in the same cycle
        if (!held || other) begin
          state_d = IDLE;
        end else if (rpt_last) begin
          if (sel_q) cmd_d[K_SLOW] = 1'b1;
          else       cmd_d[K_FAST] = 1'b1;
          rpt_cnt_d = '0;
          state_d   = REPEAT;
        end else if (rpt_cnt_q != '1) begin
          rpt_cnt_d = rpt_cnt_q + CNT_W'(1);
        end
      end
`endif
      WAIT_REL: begin
        if (deb == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // outputs straight from flops
  always_comb begin
    cmd_faster  = cmd_q[K_FAST];
    cmd_slower  = cmd_q[K_SLOW];
    cmd_restore = cmd_q[K_REST];
    key_active  = (state_q != IDLE);
  end
endmodule
